// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl: memory-stage data memory for the pipelined RISC-V core.
// Handles byte/halfword/word loads and stores with sign/zero extension,
// flags misaligned or illegal accesses, and inserts WaitStates extra cycles
// per access while holding the pipeline with stall.
// Optional feature: define RISCV_DMEM_MMIO_EN to map req_addr[31]=1 onto the
// mmio_out register instead of the array.
module riscv_dmem_ctrl #(
  parameter int Depth      = 256,
  parameter int WaitStates = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ack,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [31:0] mmio_out
);

  localparam int AW = $clog2(Depth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [2:0]     r_cnt;
  logic           r_we;
  logic [2:0]     r_funct3;
  logic [AW+1:0]  r_addr;
  logic [31:0]    r_wdata;
  logic           r_ack;
  logic           r_err;
  logic [31:0]    r_rdata;
  logic [31:0]    r_mem [Depth];

`ifdef RISCV_DMEM_MMIO_EN
  logic           r_mmioSel;
  logic [31:0]    r_mmio;
`endif

  logic           w_doAccess;
  logic           w_legal;
  logic           w_misalign;
  logic           w_err;
  logic [3:0]     w_be;
  logic [31:0]    w_wlane;
  logic [31:0]    w_word;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_loadData;
  logic           w_wrEn;
  logic           w_memWrEn;
  logic [AW-1:0]  w_wordIdx;
  logic           w_unusedAddr;

  // Address bits above the array are deliberately ignored (aliasing).
  assign w_unusedAddr = ^req_addr[31:AW+2];

  assign w_wordIdx  = r_addr[AW+1:2];
  assign w_doAccess = (r_state == S_WAIT) && (r_cnt == 3'd0);
  assign w_wrEn     = w_doAccess && r_we && !w_err;

`ifdef RISCV_DMEM_MMIO_EN
  assign w_memWrEn  = w_wrEn && !r_mmioSel;
  assign mmio_out   = r_mmio;
`else
  assign w_memWrEn  = w_wrEn;
  assign mmio_out   = 32'd0;
`endif

  assign stall   = req_valid && (r_state != S_DONE);
  assign ack     = r_ack;
  assign err     = r_err;
  assign rd_data = r_rdata;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: accept in IDLE, count wait cycles, single-cycle DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_nextState = S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Decode the captured request: legality, lane enables and load extraction.
  always_comb begin
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wlane    = r_wdata;
    w_word     = r_mem[w_wordIdx];
    w_byte     = 8'd0;
    w_half     = 16'd0;
    w_loadData = 32'd0;

`ifdef RISCV_DMEM_MMIO_EN
    if (r_mmioSel) w_word = r_mmio;
`endif

    if (r_we) w_legal = !r_funct3[2] && (r_funct3[1:0] != 2'b11);
    else      w_legal = (r_funct3[1:0] != 2'b11) && (r_funct3 != 3'b110);

    w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                 ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));

    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase

    case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_loadData = {24'd0, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b101:  w_loadData = {16'd0, w_half};
      3'b010:  w_loadData = w_word;
      default: w_loadData = 32'd0;
    endcase
  end

  assign w_err = !w_legal || w_misalign;

  // Request capture, wait counter, registered response and MMIO register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'd0;
`ifdef RISCV_DMEM_MMIO_EN
      r_mmioSel <= 1'b0;
      r_mmio    <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr[AW+1:0];
            r_wdata   <= req_wdata;
            r_cnt     <= 3'(WaitStates);
`ifdef RISCV_DMEM_MMIO_EN
            r_mmioSel <= req_addr[31];
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= (!r_we && !w_err) ? w_loadData : 32'd0;
`ifdef RISCV_DMEM_MMIO_EN
            if (w_wrEn && r_mmioSel) begin
              for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mmio[8*i +: 8] <= w_wlane[8*i +: 8];
              end
            end
`endif
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DONE: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  // Array write on the WAIT->DONE edge; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_memWrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_wordIdx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

endmodule
